fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
- Sequences front-end redirects between the fetch stage and the PC generator.
- Arbitrates between two redirect sources:
  - branch-presolve redirects, raised when the predictor said "taken" on a fetch pack with no branch;
  - backend mispredict/exception redirects.
- Holds the winning redirect until the PC unit accepts it, bumps the fetch epoch, pulses a front-end flush, then suppresses stale presolve requests for a drain window.

Parameters:
- XLEN, 64, width of PCs and targets.
- EPOCH_W, 2, width of the fetch epoch tag.
- DRAIN_CYCLES, 2, number of cycles after a flush during which presolve requests are ignored; range 0..15.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- io_i_presolve_valid  in  1  presolve pack valid
- io_i_presolve_taken  in  1  predictor taken bit carried with the pack
- io_i_presolve_pc  in  XLEN  sequential-PC redirect target from presolve
- io_i_presolve_epoch  in  EPOCH_W  epoch tag of the fetch pack that produced the request
- io_i_backend_redirect_valid  in  1  backend redirect request, single-cycle pulse
- io_i_backend_redirect_target  in  XLEN  backend redirect target
- io_o_redirect_valid  out  1  redirect offered to the PC unit
- io_i_redirect_ready  in  1  PC unit accepts the redirect
- io_o_redirect_target  out  XLEN  held redirect target
- io_o_redirect_is_backend  out  1  held redirect came from the backend
- io_o_flush_frontend  out  1  one-cycle flush pulse to fetch buffers
- io_o_epoch  out  EPOCH_W  current fetch epoch
- io_o_stall_fetch  out  1  high in PEND and DRAIN states

Behaviour:
- Reset values:
  - state=IDLE, epoch=0, drain counter=0;
  - all outputs 0, including target=0 and is_backend=0.
- States and their outputs:
  - IDLE: no redirect offered.
  - PEND: io_o_redirect_valid=1; target and is_backend driven from the holding register.
  - DRAIN: counting down the drain window.
- Qualified presolve request, pq: presolve_valid & presolve_taken & (presolve_epoch == epoch) & state==IDLE.
  - A presolve arriving in PEND or DRAIN is dropped; it is not queued.
- Backend request, bq: io_i_backend_redirect_valid, accepted in every state, including the handshake cycle.
- Capture priority, evaluated per cycle:
  - bq present: hold register <= {backend_target, is_backend=1}; next state PEND; drain counter cleared.
  - Else pq present: hold register <= {presolve_pc, is_backend=0}; next state PEND.
  - Simultaneous bq and pq in IDLE: backend wins, presolve is dropped.
- Latency: a request captured at cycle N drives io_o_redirect_valid=1 from cycle N+1. No combinational path from request inputs to outputs.
- Handshake fires when valid & ready at cycle M:
  - epoch <= epoch+1, wrapping modulo 2^EPOCH_W;
  - io_o_flush_frontend=1 for exactly cycle M+1;
  - next state DRAIN with counter=DRAIN_CYCLES, or IDLE if DRAIN_CYCLES=0.
- Handshake in cycle M with bq also asserted in M:
  - the handshake completes and the epoch increments;
  - the backend target is captured; next state PEND, not DRAIN;
  - flush pulse still occurs at M+1.
- bq while in PEND without a handshake:
  - hold register is overwritten, so the backend target replaces a pending presolve or an older backend request;
  - the epoch does not change.
- DRAIN:
  - counter decrements each cycle; at 1 -> IDLE next cycle;
  - io_o_stall_fetch=1 throughout;
  - bq moves to PEND immediately.
- io_o_redirect_valid stays high and target stays stable until ready is seen; ready while not valid has no effect.
- Asynchronous reset mid-operation: all state and outputs return to reset values immediately; the pending redirect is lost.

Test Plan:
1. Presolve redirect: epoch=0, IDLE; presolve valid=1, taken=1, epoch=0, pc=0x8000_0010 at cycle 5 -> valid=1, target=0x8000_0010, is_backend=0 at cycle 6; ready=1 at cycle 6 -> flush=1 at 7; epoch=1; stall high at 7–8; IDLE at 9.
2. Stale epoch: epoch=1; presolve with epoch=0, pc=0x100 -> no redirect_valid, state stays IDLE, epoch unchanged.
3. Collision: backend valid target=0x2000 and qualified presolve pc=0x108 in the same cycle -> next cycle target=0x2000, is_backend=1; presolve never offered.
4. Backend replaces pending presolve: presolve pc=0x108 pending with ready=0 for 3 cycles, then backend target=0x3000 -> target becomes 0x3000 next cycle; one handshake only; epoch +1.
5. Drain suppression and wrap:
   - DRAIN_CYCLES=2; qualified presolves during the drain window are dropped;
   - 4 consecutive accepted redirects take epoch 0 -> 1 -> 2 -> 3 -> 0.
6. Reset mid-PEND: assert reset while valid=1 -> valid, flush and stall go 0 immediately; epoch=0; after release, ready=1 produces no handshake.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_ctrl
//  Description : Arbitrates presolve and backend redirects, holds the winner
//                until the PC unit accepts it, then flushes and drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl #(
   parameter int unsigned XLEN         = 64,
   parameter int unsigned EPOCH_W      = 2,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               io_i_presolve_valid,
   input  logic               io_i_presolve_taken,
   input  logic [XLEN-1:0]    io_i_presolve_pc,
   input  logic [EPOCH_W-1:0] io_i_presolve_epoch,
   input  logic               io_i_backend_redirect_valid,
   input  logic [XLEN-1:0]    io_i_backend_redirect_target,
   output logic               io_o_redirect_valid,
   input  logic               io_i_redirect_ready,
   output logic [XLEN-1:0]    io_o_redirect_target,
   output logic               io_o_redirect_is_backend,
   output logic               io_o_flush_frontend,
   output logic [EPOCH_W-1:0] io_o_epoch,
   output logic               io_o_stall_fetch
);

   localparam int unsigned        CNT_W        = 4;
   localparam logic [CNT_W-1:0]   c_DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0]   c_CNT_ONE    = CNT_W'(1);
   localparam logic [EPOCH_W-1:0] c_EPOCH_ONE  = EPOCH_W'(1);
   localparam logic               c_HAS_DRAIN  = (DRAIN_CYCLES != 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PEND  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [EPOCH_W-1:0] r_epoch;
   logic [XLEN-1:0]    r_target;
   logic               r_is_backend;
   logic               r_valid;
   logic               r_flush;
   logic               r_stall;

   logic w_bq;
   logic w_pq;
   logic w_hs;

   assign w_bq = io_i_backend_redirect_valid;
   assign w_pq = io_i_presolve_valid & io_i_presolve_taken &
                 (io_i_presolve_epoch == r_epoch) & (r_state == S_IDLE);
   // r_valid is high exactly while in PEND, so this is the only handshake qualifier
   assign w_hs = r_valid & io_i_redirect_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_epoch      <= '0;
         r_target     <= '0;
         r_is_backend <= 1'b0;
         r_valid      <= 1'b0;
         r_flush      <= 1'b0;
         r_stall      <= 1'b0;
      end else begin
         r_flush <= w_hs;
         if (w_hs) begin
            r_epoch <= r_epoch + c_EPOCH_ONE;
         end

         // A backend request overrides everything, including a completing handshake
         if (w_bq) begin
            r_target     <= io_i_backend_redirect_target;
            r_is_backend <= 1'b1;
            r_state      <= S_PEND;
            r_cnt        <= '0;
            r_valid      <= 1'b1;
            r_stall      <= 1'b1;
         end else if (w_hs) begin
            r_valid <= 1'b0;
            if (c_HAS_DRAIN) begin
               r_state <= S_DRAIN;
               r_cnt   <= c_DRAIN_LOAD;
               r_stall <= 1'b1;
            end else begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_stall <= 1'b0;
            end
         end else if (w_pq) begin
            r_target     <= io_i_presolve_pc;
            r_is_backend <= 1'b0;
            r_state      <= S_PEND;
            r_valid      <= 1'b1;
            r_stall      <= 1'b1;
         end else if (r_state == S_DRAIN) begin
            if (r_cnt <= c_CNT_ONE) begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_stall <= 1'b0;
            end else begin
               r_cnt <= r_cnt - c_CNT_ONE;
            end
         end
      end
   end

   assign io_o_redirect_valid      = r_valid;
   assign io_o_redirect_target     = r_target;
   assign io_o_redirect_is_backend = r_is_backend;
   assign io_o_flush_frontend      = r_flush;
   assign io_o_epoch               = r_epoch;
   assign io_o_stall_fetch         = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_redirect_ctrl
//  Description : Directed self-checking bench for fetch_redirect_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_ctrl;

   localparam int unsigned XLEN    = 64;
   localparam int unsigned EPOCH_W = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               p_valid = 1'b0;
   logic               p_taken = 1'b0;
   logic [XLEN-1:0]    p_pc = '0;
   logic [EPOCH_W-1:0] p_epoch = '0;
   logic               b_valid = 1'b0;
   logic [XLEN-1:0]    b_target = '0;
   logic               ready = 1'b0;
   logic               o_valid;
   logic [XLEN-1:0]    o_target;
   logic               o_is_be;
   logic               o_flush;
   logic [EPOCH_W-1:0] o_epoch;
   logic               o_stall;

   int vectors = 0;
   int miscompares = 0;

   fetch_redirect_ctrl #(.XLEN(XLEN), .EPOCH_W(EPOCH_W), .DRAIN_CYCLES(2)) dut (
      .clock                        (clk),
      .reset                        (rst),
      .io_i_presolve_valid          (p_valid),
      .io_i_presolve_taken          (p_taken),
      .io_i_presolve_pc             (p_pc),
      .io_i_presolve_epoch          (p_epoch),
      .io_i_backend_redirect_valid  (b_valid),
      .io_i_backend_redirect_target (b_target),
      .io_o_redirect_valid          (o_valid),
      .io_i_redirect_ready          (ready),
      .io_o_redirect_target         (o_target),
      .io_o_redirect_is_backend     (o_is_be),
      .io_o_flush_frontend          (o_flush),
      .io_o_epoch                   (o_epoch),
      .io_o_stall_fetch             (o_stall)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      vectors++;
      if ({o_valid, o_flush, o_stall, o_is_be} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: got v/f/s/b=%b required 0000", {o_valid, o_flush, o_stall, o_is_be});
      end
      vectors++;
      if (o_epoch !== 2'd0 || o_target !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_regs: got epoch=%0d target=%h required 0/0", o_epoch, o_target);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_presolve();
      p_valid = 1'b1; p_taken = 1'b1; p_epoch = 2'd0; p_pc = 64'h8000_0010;
      step();
      p_valid = 1'b0; p_taken = 1'b0;
      vectors++;
      if (o_valid !== 1'b1 || o_target !== 64'h8000_0010 || o_is_be !== 1'b0 || o_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL presolve_offer: got v=%b t=%h be=%b s=%b required 1 80000010 0 1", o_valid, o_target, o_is_be, o_stall);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      vectors++;
      if (o_flush !== 1'b1 || o_epoch !== 2'd1 || o_valid !== 1'b0 || o_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL presolve_hs: got f=%b e=%0d v=%b s=%b required 1 1 0 1", o_flush, o_epoch, o_valid, o_stall);
      end
      step();
      vectors++;
      if (o_flush !== 1'b0 || o_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL presolve_drain: got f=%b s=%b required 0 1", o_flush, o_stall);
      end
      step();
      vectors++;
      if (o_stall !== 1'b0 || o_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL presolve_idle: got s=%b v=%b required 0 0", o_stall, o_valid);
      end
   endtask

   task automatic test_stale_epoch();
      p_valid = 1'b1; p_taken = 1'b1; p_epoch = 2'd0; p_pc = 64'h100;
      step();
      p_valid = 1'b0; p_taken = 1'b0;
      vectors++;
      if (o_valid !== 1'b0 || o_stall !== 1'b0 || o_epoch !== 2'd1) begin
         miscompares++;
         $display("FAIL stale_epoch: got v=%b s=%b e=%0d required 0 0 1", o_valid, o_stall, o_epoch);
      end
      // untaken pack with a matching epoch is not a request either
      p_valid = 1'b1; p_taken = 1'b0; p_epoch = 2'd1;
      step();
      p_valid = 1'b0;
      vectors++;
      if (o_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL not_taken: got v=%b required 0", o_valid);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      vectors++;
      if (o_flush !== 1'b0 || o_epoch !== 2'd1) begin
         miscompares++;
         $display("FAIL ready_no_valid: got f=%b e=%0d required 0 1", o_flush, o_epoch);
      end
   endtask

   task automatic test_collision();
      b_valid = 1'b1; b_target = 64'h2000;
      p_valid = 1'b1; p_taken = 1'b1; p_epoch = 2'd1; p_pc = 64'h108;
      step();
      b_valid = 1'b0; p_valid = 1'b0; p_taken = 1'b0;
      vectors++;
      if (o_valid !== 1'b1 || o_target !== 64'h2000 || o_is_be !== 1'b1) begin
         miscompares++;
         $display("FAIL collision_offer: got v=%b t=%h be=%b required 1 2000 1", o_valid, o_target, o_is_be);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      vectors++;
      if (o_flush !== 1'b1 || o_epoch !== 2'd2 || o_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL collision_hs: got f=%b e=%0d v=%b required 1 2 0", o_flush, o_epoch, o_valid);
      end
      step();
      step();
      step();
      vectors++;
      if (o_valid !== 1'b0 || o_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL collision_dropped: got v=%b s=%b required 0 0", o_valid, o_stall);
      end
   endtask

   task automatic test_backend_replace();
      p_valid = 1'b1; p_taken = 1'b1; p_epoch = 2'd2; p_pc = 64'h108;
      step();
      p_valid = 1'b0; p_taken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (o_valid !== 1'b1 || o_target !== 64'h108 || o_is_be !== 1'b0) begin
            miscompares++;
            $display("FAIL replace_hold[%0d]: got v=%b t=%h be=%b required 1 108 0", i, o_valid, o_target, o_is_be);
         end
         step();
      end
      b_valid = 1'b1; b_target = 64'h3000;
      step();
      b_valid = 1'b0;
      vectors++;
      if (o_valid !== 1'b1 || o_target !== 64'h3000 || o_is_be !== 1'b1 || o_epoch !== 2'd2) begin
         miscompares++;
         $display("FAIL replace_offer: got v=%b t=%h be=%b e=%0d required 1 3000 1 2", o_valid, o_target, o_is_be, o_epoch);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      vectors++;
      if (o_flush !== 1'b1 || o_epoch !== 2'd3 || o_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL replace_hs: got f=%b e=%0d v=%b required 1 3 0", o_flush, o_epoch, o_valid);
      end
      step();
      vectors++;
      if (o_flush !== 1'b0 || o_valid !== 1'b0 || o_epoch !== 2'd3) begin
         miscompares++;
         $display("FAIL replace_single: got f=%b v=%b e=%0d required 0 0 3", o_flush, o_valid, o_epoch);
      end
      step();
   endtask

   task automatic test_drain_wrap();
      logic [EPOCH_W-1:0] exp_epoch;
      p_valid = 1'b1; p_taken = 1'b1; p_epoch = 2'd3; p_pc = 64'h40;
      step();
      p_valid = 1'b0;
      ready = 1'b1;
      step();
      ready = 1'b0;
      vectors++;
      if (o_epoch !== 2'd0 || o_flush !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_first: got e=%0d f=%b required 0 1", o_epoch, o_flush);
      end
      // qualified-looking presolve across the whole drain window
      p_valid = 1'b1; p_taken = 1'b1; p_epoch = 2'd0; p_pc = 64'h44;
      step();
      vectors++;
      if (o_valid !== 1'b0 || o_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_suppress: got v=%b s=%b required 0 1", o_valid, o_stall);
      end
      step();
      p_valid = 1'b0; p_taken = 1'b0;
      vectors++;
      if (o_valid !== 1'b0 || o_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_exit: got v=%b s=%b required 0 0", o_valid, o_stall);
      end
      step();
      vectors++;
      if (o_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_not_queued: got v=%b required 0", o_valid);
      end
      exp_epoch = 2'd0;
      for (int i = 0; i < 4; i++) begin
         b_valid = 1'b1; b_target = 64'h5000 + 64'(i);
         step();
         b_valid = 1'b0;
         vectors++;
         if (o_valid !== 1'b1 || o_target !== 64'h5000 + 64'(i)) begin
            miscompares++;
            $display("FAIL wrap_offer[%0d]: got v=%b t=%h required 1 %h", i, o_valid, o_target, 64'h5000 + 64'(i));
         end
         ready = 1'b1;
         step();
         ready = 1'b0;
         exp_epoch = exp_epoch + 2'd1;
         vectors++;
         if (o_epoch !== exp_epoch) begin
            miscompares++;
            $display("FAIL wrap_epoch[%0d]: got %0d required %0d", i, o_epoch, exp_epoch);
         end
         step();
         step();
      end
   endtask

   task automatic test_back_to_back();
      b_valid = 1'b1; b_target = 64'h7000;
      step();
      b_target = 64'h7100;
      ready = 1'b1;
      step();
      b_valid = 1'b0; ready = 1'b0;
      vectors++;
      if (o_flush !== 1'b1 || o_epoch !== 2'd1 || o_valid !== 1'b1 || o_target !== 64'h7100 || o_is_be !== 1'b1) begin
         miscompares++;
         $display("FAIL hs_plus_bq: got f=%b e=%0d v=%b t=%h be=%b required 1 1 1 7100 1", o_flush, o_epoch, o_valid, o_target, o_is_be);
      end
      step();
      vectors++;
      if (o_flush !== 1'b0 || o_valid !== 1'b1 || o_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL hs_plus_bq_hold: got f=%b v=%b s=%b required 0 1 1", o_flush, o_valid, o_stall);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      b_valid = 1'b1; b_target = 64'h7200;
      step();
      b_valid = 1'b0;
      vectors++;
      if (o_valid !== 1'b1 || o_target !== 64'h7200 || o_epoch !== 2'd2 || o_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_bq: got v=%b t=%h e=%0d s=%b required 1 7200 2 1", o_valid, o_target, o_epoch, o_stall);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset_mid();
      p_valid = 1'b1; p_taken = 1'b1; p_epoch = 2'd3; p_pc = 64'h900;
      step();
      p_valid = 1'b0; p_taken = 1'b0;
      vectors++;
      if (o_valid !== 1'b1 || o_epoch !== 2'd3) begin
         miscompares++;
         $display("FAIL mid_pend: got v=%b e=%0d required 1 3", o_valid, o_epoch);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (o_valid !== 1'b0 || o_flush !== 1'b0 || o_stall !== 1'b0 || o_epoch !== 2'd0) begin
         miscompares++;
         $display("FAIL async_reset: got v=%b f=%b s=%b e=%0d required 0 0 0 0", o_valid, o_flush, o_stall, o_epoch);
      end
      step();
      rst = 1'b0;
      ready = 1'b1;
      step();
      ready = 1'b0;
      vectors++;
      if (o_flush !== 1'b0 || o_epoch !== 2'd0 || o_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_ready: got f=%b e=%0d v=%b required 0 0 0", o_flush, o_epoch, o_valid);
      end
   endtask

   initial begin
      test_reset();
      test_presolve();
      test_stale_epoch();
      test_collision();
      test_backend_replace();
      test_drain_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
